// File: rtl/midi_tx_sched.sv
// midi_tx_sched: round-robin scheduler that shares one MIDI UART transmitter
// between N_REQ message sources. It latches one 1-3 byte message per grant,
// streams it over a byte valid/ready handshake, and can use MIDI running
// status so that a repeated channel status byte is left out.
module midi_tx_sched #(
  parameter int          N_REQ          = 2,
  parameter int          RUNNING_STATUS = 1,
  parameter logic [15:0] RS_TIMEOUT     = 16'd50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*24-1:0]   req_msg,
  output logic [N_REQ-1:0]      grant,
  output logic                  drop,
  output logic                  busy,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int                PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W:0]    N_VAL = (PTR_W+1)'(N_REQ);
  localparam logic [PTR_W-1:0]  LAST  = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, S_STAT, S_D1, S_D2} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [23:0]      msg_q, msg_d;
  logic [1:0]       len_q, len_d;
  logic [7:0]       rs_q, rs_d;
  logic             rs_valid_q, rs_valid_d;
  logic [15:0]      cnt_q, cnt_d;

  // Requests rotated so that bit 0 is the requester the pointer favours.
  logic [2*N_REQ-1:0] rot2;
  logic [N_REQ-1:0]   rot;
  logic               found;
  logic [PTR_W-1:0]   off;
  logic [PTR_W:0]     sum;
  logic [PTR_W-1:0]   win;
  logic [23:0]        win_msg;
  logic [7:0]         win_stat;
  logic               win_bad;
  logic               win_rt;
  logic [1:0]         win_len;
  logic               xfer;

  // Bits that are deliberately never consumed (upper rotation copy, data MSBs).
  logic unused_bits;
  assign unused_bits = ^{rot2[2*N_REQ-1:N_REQ], msg_q[15], msg_q[7]};

  assign rot2 = {req, req} >> ptr_q;
  assign rot  = rot2[N_REQ-1:0];

  // Lowest set bit of the rotated request vector is the round-robin winner.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = PTR_W'(k);
      end
    end
  end

  assign sum = {1'b0, ptr_q} + {1'b0, off};
  assign win = (sum >= N_VAL) ? PTR_W'(sum - N_VAL) : sum[PTR_W-1:0];

  // Select the winner's message and classify its status byte.
  always_comb begin
    win_msg = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == PTR_W'(i)) win_msg = req_msg[24*i +: 24];
    end
    win_stat = win_msg[23:16];
    win_bad  = !win_stat[7] || (win_stat[7:3] == 5'b11110);
    win_rt   = (win_stat[7:3] == 5'b11111);
    if (win_rt)                                              win_len = 2'd1;
    else if (win_stat[7:4] == 4'hC || win_stat[7:4] == 4'hD) win_len = 2'd2;
    else                                                     win_len = 2'd3;
  end

  // Next-state, handshake outputs and running-status bookkeeping.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    msg_d      = msg_q;
    len_d      = len_q;
    rs_d       = rs_q;
    rs_valid_d = rs_valid_q;
    cnt_d      = cnt_q;
    grant      = '0;
    drop       = 1'b0;
    busy       = (state_q != IDLE);
    tx_valid   = 1'b0;
    tx_data    = 8'h00;

    // The timeout invalidates first so a status transfer below can re-arm it.
    if (RS_TIMEOUT != 16'd0 && cnt_q == RS_TIMEOUT) rs_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (found && !rst) begin
          for (int i = 0; i < N_REQ; i++) grant[i] = (win == PTR_W'(i));
          ptr_d = (win == LAST) ? '0 : win + 1'b1;
          msg_d = win_msg;
          len_d = win_len;
          if (win_bad) begin
            drop = 1'b1;
          end else if (RUNNING_STATUS != 0 && !win_rt && rs_valid_q && rs_q == win_stat) begin
            state_d = S_D1;
          end else begin
            state_d = S_STAT;
          end
        end
      end
      S_STAT: begin
        tx_valid = 1'b1;
        tx_data  = msg_q[23:16];
        if (tx_ready) begin
          if (len_q == 2'd1) begin
            state_d = IDLE;
          end else begin
            rs_d       = msg_q[23:16];
            rs_valid_d = 1'b1;
            state_d    = S_D1;
          end
        end
      end
      S_D1: begin
        tx_valid = 1'b1;
        tx_data  = {1'b0, msg_q[14:8]};
        if (tx_ready) state_d = (len_q == 2'd3) ? S_D2 : IDLE;
      end
      default: begin
        tx_valid = 1'b1;
        tx_data  = {1'b0, msg_q[6:0]};
        if (tx_ready) state_d = IDLE;
      end
    endcase

    xfer = tx_valid && tx_ready;
    if (xfer)                                   cnt_d = 16'd0;
    else if (state_q == IDLE && cnt_q != RS_TIMEOUT) cnt_d = cnt_q + 16'd1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      msg_q      <= '0;
      len_q      <= '0;
      rs_q       <= '0;
      rs_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      msg_q      <= msg_d;
      len_q      <= len_d;
      rs_q       <= rs_d;
      rs_valid_q <= rs_valid_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_midi_tx_sched.sv
// Bench for midi_tx_sched: a queue-based model of the byte stream and the
// round-robin pointer is checked against the DUT every cycle; directed tests
// additionally compare the logged bytes/grants against hand-written values.
module tb_midi_tx_sched;
  localparam int N = 2;
  localparam int T = 100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*24-1:0]  req_msg = '0;
  logic [N-1:0]     grant;
  logic             drop;
  logic             busy;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b1;

  midi_tx_sched #(.N_REQ(N), .RUNNING_STATUS(1), .RS_TIMEOUT(16'd100)) dut (
    .clk(clk), .rst(rst), .req(req), .req_msg(req_msg), .grant(grant),
    .drop(drop), .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state
  int         m_ptr = 0;
  bit         m_rs_valid = 0;
  logic [7:0] m_rs = 8'h00;
  int         m_idle = 0;
  logic [8:0] m_q[$];   // {sets_running_status, byte}

  // Logs for the directed checks
  logic [7:0] byte_log[$];
  int         grant_log[$];
  int         drop_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle model and comparison, sampled on the falling edge.
  always @(negedge clk) begin
    logic [N-1:0] exp_grant;
    bit           exp_drop;
    bit           idle;
    int           w;
    logic [23:0]  msg;
    logic [7:0]   s;
    logic [8:0]   e;
    if (rst) begin
      m_ptr = 0; m_rs_valid = 0; m_rs = 8'h00; m_idle = 0; m_q.delete();
    end else begin
      exp_grant = '0;
      exp_drop  = 0;
      idle      = (m_q.size() == 0);
      if (idle && req != '0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        exp_grant[w] = 1'b1;
        m_ptr = (w + 1) % N;
        msg = req_msg[24*w +: 24];
        s = msg[23:16];
        if (s < 8'h80 || (s >= 8'hF0 && s <= 8'hF7)) begin
          exp_drop = 1;
        end else if (s >= 8'hF8) begin
          m_q.push_back({1'b0, s});
        end else begin
          if (!(m_rs_valid && m_rs == s)) m_q.push_back({1'b1, s});
          m_q.push_back({2'b00, msg[14:8]});
          if (!(s[7:4] == 4'hC || s[7:4] == 4'hD)) m_q.push_back({2'b00, msg[6:0]});
        end
      end
      chk("grant", 32'(grant), 32'(exp_grant));
      chk("drop", 32'(drop), 32'(exp_drop));
      chk("busy", 32'(busy), 32'(!idle));
      chk("tx_valid", 32'(tx_valid), 32'(!idle));
      if (!idle) chk("tx_data", 32'(tx_data), 32'(m_q[0][7:0]));
      else       chk("tx_data_idle", 32'(tx_data), 32'h0);

      if (grant != '0) grant_log.push_back(int'(grant));
      if (drop) drop_cnt++;
      if (tx_valid && tx_ready) byte_log.push_back(tx_data);

      if (!idle && tx_ready) begin
        e = m_q.pop_front();
        if (e[8]) begin m_rs = e[7:0]; m_rs_valid = 1; end
        m_idle = 0;
      end else if (idle) begin
        if (m_idle < T) m_idle++;
        if (m_idle >= T) m_rs_valid = 0;
      end
    end
  end

  task automatic clear_logs();
    @(posedge clk); #1;
    byte_log.delete();
    grant_log.delete();
    drop_cnt = 0;
  endtask

  task automatic send(input int idx, input logic [23:0] msg);
    bit got;
    @(posedge clk); #1;
    req_msg[24*idx +: 24] = msg;
    req[idx] = 1'b1;
    got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (grant[idx]) got = 1;
    end
    if (!got) chk("grant_timeout", 32'(got), 32'h1);
    @(posedge clk); #1;
    req[idx] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) chk("idle_timeout", 32'(done), 32'h1);
  endtask

  task automatic check_bytes(input string name, input logic [7:0] exp[$]);
    chk({name, "_count"}, 32'(byte_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < byte_log.size(); i++)
      chk(name, 32'(byte_log[i]), 32'(exp[i]));
  endtask

  task automatic check_grants(input string name, input int exp[$]);
    chk({name, "_count"}, 32'(grant_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
      chk(name, 32'(grant_log[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] stall_exp[3];
    bit         done;
    stall_exp[0] = 8'hB0; stall_exp[1] = 8'h07; stall_exp[2] = 8'h7F;

    // Reset values
    @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_drop", 32'(drop), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: note-on from requester 0
    clear_logs();
    send(0, 24'h903C64); wait_idle();
    check_bytes("t1_bytes", '{8'h90, 8'h3C, 8'h64});
    check_grants("t1_grant", '{1});

    // 2: running status suppresses the repeated 0x90, then times out
    clear_logs();
    send(0, 24'h90407F); wait_idle();
    check_bytes("t2_rs_bytes", '{8'h40, 8'h7F});
    repeat (150) @(posedge clk);
    clear_logs();
    send(0, 24'h903C00); wait_idle();
    check_bytes("t2_timeout_bytes", '{8'h90, 8'h3C, 8'h00});

    // 3: round robin (pointer brought back to 0 by a requester-1 message)
    send(1, 24'hFE0000); wait_idle();
    clear_logs();
    req_msg[23:0] = 24'hF80000;
    req_msg[47:24] = 24'hFA0000;
    req = 2'b11;
    done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (grant_log.size() >= 4) done = 1;
    end
    @(posedge clk); #1 req = 2'b00;
    wait_idle();
    check_grants("t3_alternate", '{1, 2, 1, 2});
    clear_logs();
    req = 2'b10;
    done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (grant_log.size() >= 3) done = 1;
    end
    @(posedge clk); #1 req = 2'b00;
    wait_idle();
    check_grants("t3_single", '{2, 2, 2});

    // 4: backpressure, data2 MSB masked
    clear_logs();
    tx_ready = 1'b0;
    send(0, 24'hB007FF);
    for (int b = 0; b < 3; b++) begin
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("t4_stall_data", 32'(tx_data), 32'(stall_exp[b]));
      @(posedge clk); #1 tx_ready = 1'b1;
      @(posedge clk); #1 tx_ready = 1'b0;
    end
    tx_ready = 1'b1;
    wait_idle();
    check_bytes("t4_bytes", '{8'hB0, 8'h07, 8'h7F});

    // 5: lengths and dropping
    clear_logs();
    send(0, 24'hC50A33); wait_idle();
    check_bytes("t5_prog", '{8'hC5, 8'h0A});
    clear_logs();
    send(1, 24'hF80000); wait_idle();
    check_bytes("t5_rt", '{8'hF8});
    clear_logs();
    send(0, 24'hC51122); wait_idle();
    check_bytes("t5_rs_kept", '{8'h11});
    clear_logs();
    send(0, 24'hF01234); wait_idle();
    send(1, 24'h401234); wait_idle();
    chk("t5_drops", 32'(drop_cnt), 32'd2);
    chk("t5_no_bytes", 32'(byte_log.size()), 32'd0);

    // 6: reset in the middle of a message
    tx_ready = 1'b0;
    send(0, 24'h803C40);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_valid_after_rst", 32'(tx_valid), 32'h0);
    chk("t6_busy_after_rst", 32'(busy), 32'h0);
    tx_ready = 1'b1;
    clear_logs();
    send(0, 24'h803C40); wait_idle();
    check_bytes("t6_resend", '{8'h80, 8'h3C, 8'h40});

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/midi_tx_sched.md
Name: midi_tx_sched

Overview:
- Shares the single MIDI UART transmitter between N_REQ message sources, such as button event generators and the MIDI-thru path.
- Arbitrates round-robin and latches one complete message per grant.
- Serialises the message as 1–3 bytes over a byte valid/ready handshake to the UART TX.
- Optionally applies MIDI running status to suppress repeated status bytes.

Parameters:
N_REQ, 2, number of requesters (1..8)
RUNNING_STATUS, 1, 1 = omit status byte when equal to last transmitted channel status
RS_TIMEOUT, 16'd50000, clk cycles of TX idle after which the running-status memory is invalidated (0 = never)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  N_REQ  per-requester message pending; held until grant
req_msg  in  N_REQ*24  per-requester message {status[23:16], data1[15:8], data2[7:0]}; requester i at bits [24*i+23:24*i]
grant  out  N_REQ  one-hot, one-cycle pulse: message of requester i latched this cycle
drop  out  1  one-cycle pulse: latched message was invalid/unsupported and was discarded
busy  out  1  high in any state other than IDLE
tx_data  out  8  byte to UART TX
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART TX accepts byte (transfer = tx_valid & tx_ready)

Behaviour:
- Reset values:
  - grant=0, drop=0, busy=0, tx_valid=0, tx_data=0.
  - Round-robin pointer=0.
  - Running-status register invalid; timeout counter=0; FSM=IDLE.
- FSM states: IDLE, S_STAT, S_D1, S_D2.
- IDLE, req!=0:
  - Winner = first set req bit at or after the pointer, wrapping modulo N_REQ.
  - Latch the winner's req_msg; pulse grant[winner] in that same cycle.
  - Pointer <= winner+1, mod N_REQ.
  - Classify the latched status byte S:
    - S[7]=0 or S in F0..F7: pulse drop the same cycle, stay IDLE, send nothing.
    - S in 80..EF, channel message: length 3 for 8x/9x/Ax/Bx/Ex, length 2 for Cx/Dx.
    - S in F8..FF, realtime: length 1.
  - Next state:
    - Channel message, RUNNING_STATUS=1, running status valid and equal to S: go to S_D1.
    - All other valid messages: go to S_STAT.
- S_STAT: tx_valid=1, tx_data=S. On transfer:
  - Length 1: go to IDLE; running status is unchanged.
  - Otherwise: running status <= S (valid); go to S_D1.
- S_D1: tx_valid=1, tx_data={1'b0,data1[6:0]}. On transfer:
  - Length 3: go to S_D2.
  - Otherwise: go to IDLE.
- S_D2: tx_valid=1, tx_data={1'b0,data2[6:0]}. On transfer: go to IDLE.
- Handshake:
  - tx_data is stable while tx_valid=1 and tx_ready=0.
  - tx_valid may stay high across consecutive bytes of one message, with no bubble.
  - tx_valid=0 in IDLE.
  - Minimum one IDLE cycle between messages; grant never pulses while busy=1.
- Latency: req seen in IDLE at cycle n -> grant at cycle n -> tx_valid=1 at cycle n+1.
- Data bits [7] of data1/data2 are forced to 0.
- Running-status timeout:
  - The counter resets to 0 on every transfer and increments while IDLE.
  - When RS_TIMEOUT!=0 and the counter reaches RS_TIMEOUT, running status is invalidated.
  - The counter saturates at RS_TIMEOUT.
- A req deasserted before grant is simply not served; there is no error.
- rst asserted mid-message: the next cycle is IDLE with tx_valid=0, the partial message is abandoned, and running status is invalid. Consequently the next channel message always starts with its status byte.
- RUNNING_STATUS=0: the status byte is always sent.
- N_REQ=1: the pointer stays 0.

Test Plan:
1. Note-on, single requester:
   - Stimulus: req[0] with 0x90_3C_64, tx_ready=1.
   - Required: grant[0] for 1 cycle; bytes 90,3C,64 on consecutive cycles; busy low after the last byte.
2. Running status and its timeout:
   - Stimulus: 0x90_3C_64 then 0x90_40_7F, RS_TIMEOUT=100.
   - Required: bytes 90,3C,64,40,7F.
   - Then: after >100 idle cycles, 0x90_3C_00 -> 90,3C,00.
3. Round-robin fairness:
   - Stimulus: N_REQ=2, req=2'b11 held, re-raised after each grant.
   - Required: grants alternate 01,10,01,10.
   - Then: with only req[1] set, grant[1] repeats every message.
4. Backpressure:
   - Stimulus: 0xB0_07_FF; tx_ready low for 5 cycles on each byte.
   - Required: tx_data holds B0 / 07 / 7F (data2 masked) while stalled; exactly 3 transfers.
5. Lengths and dropping:
   - Stimulus: 0xC5_0A_xx, then 0xF8, then 0xF0, then 0x40 status.
   - Required:
     - 0xC5_0A_xx: C5,0A only.
     - 0xF8: F8 only; running status still C5.
     - 0xF0 and 0x40: drop pulse each, no bytes.
6. Reset mid-message:
   - Stimulus: rst asserted in S_D1 of 0x80_3C_40 with tx_ready=0, then 0x80_3C_40 again.
   - Required: tx_valid=0 and busy=0 the cycle after rst; the resend starts with 80 (status not suppressed).
